mole_board: RTL and testbench

MOLE_BOARD -- requirements
Module: mole_board

---
 rtl/mole_pkg.sv | 18 +
 rtl/button_pulse.sv | 50 +++++
 rtl/mole_board.sv | 110 +++++++++++
 tb/tb_mole_board.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared defaults and helpers for the whack-a-mole board.
package mole_pkg;

  localparam int DEF_N_HOLES = 5;
  localparam int DEF_LIFE_W  = 8;
  localparam int MAX_HOLES   = 16;

  // Number of set bits in a hole vector of up to MAX_HOLES bits.
  function automatic logic [4:0] popcount(input logic [MAX_HOLES-1:0] bits);
    logic [4:0] total;
    total = '0;
    for (int i = 0; i < MAX_HOLES; i++) begin
      total = total + 5'(bits[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/button_pulse.sv
// Synchronises raw button levels and turns each new press into a one-cycle pulse.
// A button that is already high when reset releases must be seen low once
// before it is allowed to produce a press.
module button_pulse #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] button_i,
  output logic [WIDTH-1:0] press_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] enable_q, enable_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [1:0]       fillCnt_q, fillCnt_d;
  logic             pipeValid;

  // sync2 only holds real button data once two edges have passed since reset.
  assign pipeValid = (fillCnt_q == 2'd2);

  // Next-state for the fill counter, per-bit arming and the edge detector.
  always_comb begin
    fillCnt_d = pipeValid ? fillCnt_q : fillCnt_q + 2'd1;
    enable_d  = enable_q | ({WIDTH{pipeValid}} & ~sync2_q);
    press_d   = enable_q & sync2_q & ~prev_q;
  end

  // Synchroniser chain, previous-level flop and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      enable_q  <= '0;
      press_q   <= '0;
      fillCnt_q <= '0;
    end else begin
      sync1_q   <= button_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      enable_q  <= enable_d;
      press_q   <= press_d;
      fillCnt_q <= fillCnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/mole_board.sv
// Whack-a-mole board: per-hole lifetime counters, hit/miss/whiff scoring.
module mole_board
  import mole_pkg::*;
#(
  parameter int N_HOLES = DEF_N_HOLES,
  parameter int LIFE_W  = DEF_LIFE_W,
  parameter int CNT_W   = $clog2(N_HOLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               load,
  input  logic [N_HOLES-1:0] load_mask,
  input  logic [LIFE_W-1:0]  load_life,
  input  logic [N_HOLES-1:0] button,
  output logic [N_HOLES-1:0] board_state,
  output logic               score_trigger,
  output logic [CNT_W-1:0]   hit_count,
  output logic               miss_trigger,
  output logic               whiff_trigger
);

  logic [N_HOLES-1:0] press;
  logic [N_HOLES-1:0] active;
  logic [N_HOLES-1:0] hit;
  logic [N_HOLES-1:0] expire;
  logic [N_HOLES-1:0] whiffHoles;
  logic               loadValid;

  logic [LIFE_W-1:0]  life_q [N_HOLES];
  logic [LIFE_W-1:0]  life_d [N_HOLES];
  logic [N_HOLES-1:0] boardState_q, boardState_d;
  logic               score_q, score_d;
  logic [CNT_W-1:0]   hitCount_q, hitCount_d;
  logic               miss_q, miss_d;
  logic               whiff_q, whiff_d;

  button_pulse #(
    .WIDTH(N_HOLES)
  ) u_button_pulse (
    .clk     (clk),
    .rst_n   (rst_n),
    .button_i(button),
    .press_o (press)
  );

  // A load with zero lifetime is a no-op.
  assign loadValid = load & (load_life != '0);

  // Per-hole lifetime update: hit clears, tick decrements, a valid load overrides both.
  // Hits are judged against the pre-load state so a re-armed hole can still score.
  always_comb begin
    for (int i = 0; i < N_HOLES; i++) begin
      active[i]     = (life_q[i] != '0);
      hit[i]        = press[i] & active[i];
      whiffHoles[i] = press[i] & ~active[i];
      life_d[i]     = life_q[i];
      expire[i]     = 1'b0;
      if (hit[i]) begin
        life_d[i] = '0;
      end else if (tick && active[i]) begin
        life_d[i] = life_q[i] - 1'b1;
        expire[i] = (life_q[i] == LIFE_W'(1));
      end
      if (loadValid && load_mask[i]) begin
        life_d[i] = load_life;
        expire[i] = 1'b0;
      end
      boardState_d[i] = (life_d[i] != '0);
    end
  end

  // Trigger and count outputs for the current cycle's events.
  always_comb begin
    hitCount_d = CNT_W'(popcount(MAX_HOLES'(hit)));
    score_d    = |hit;
    miss_d     = |expire;
    whiff_d    = |whiffHoles;
  end

  // Lifetime counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_HOLES; i++) begin
        life_q[i] <= '0;
      end
      boardState_q <= '0;
      score_q      <= 1'b0;
      hitCount_q   <= '0;
      miss_q       <= 1'b0;
      whiff_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N_HOLES; i++) begin
        life_q[i] <= life_d[i];
      end
      boardState_q <= boardState_d;
      score_q      <= score_d;
      hitCount_q   <= hitCount_d;
      miss_q       <= miss_d;
      whiff_q      <= whiff_d;
    end
  end

  assign board_state   = boardState_q;
  assign score_trigger = score_q;
  assign hit_count     = hitCount_q;
  assign miss_trigger  = miss_q;
  assign whiff_trigger = whiff_q;

endmodule

// File: tb/tb_mole_board.sv
// Directed self-checking bench for mole_board with N_HOLES=5, LIFE_W=8.
module tb_mole_board;

  localparam int N = 5;
  localparam int LW = 8;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          tick;
  logic          load;
  logic [N-1:0]  load_mask;
  logic [LW-1:0] load_life;
  logic [N-1:0]  button;
  logic [N-1:0]  board_state;
  logic          score_trigger;
  logic [CW-1:0] hit_count;
  logic          miss_trigger;
  logic          whiff_trigger;

  int assertCount = 0;
  int failCount   = 0;

  mole_board #(
    .N_HOLES(N),
    .LIFE_W (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .load         (load),
    .load_mask    (load_mask),
    .load_life    (load_life),
    .button       (button),
    .board_state  (board_state),
    .score_trigger(score_trigger),
    .hit_count    (hit_count),
    .miss_trigger (miss_trigger),
    .whiff_trigger(whiff_trigger)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles, leaving time 1 unit after the rising edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [N-1:0] expBoard, input logic expScore,
                          input logic [CW-1:0] expHits, input logic expMiss, input logic expWhiff);
    checkOutput({tag, ".board"}, 32'(board_state), 32'(expBoard));
    checkOutput({tag, ".score"}, 32'(score_trigger), 32'(expScore));
    checkOutput({tag, ".hits"}, 32'(hit_count), 32'(expHits));
    checkOutput({tag, ".miss"}, 32'(miss_trigger), 32'(expMiss));
    checkOutput({tag, ".whiff"}, 32'(whiff_trigger), 32'(expWhiff));
  endtask

  // Linear directed scenario.
  initial begin
    rst_n = 1'b0; tick = 1'b0; load = 1'b0;
    load_mask = '0; load_life = '0; button = '0;

    // Reset state
    applyStimulus(2);
    checkAll("reset", 5'b00000, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(4);

    // Arm 10101 with life 3, then three ticks expire them all at once
    load = 1'b1; load_mask = 5'b10101; load_life = 8'd3;
    applyStimulus(1);
    load = 1'b0;
    checkAll("arm", 5'b10101, 0, 0, 0, 0);
    tick = 1'b1;
    applyStimulus(1);
    checkAll("tick1", 5'b10101, 0, 0, 0, 0);
    applyStimulus(1);
    checkAll("tick2", 5'b10101, 0, 0, 0, 0);
    applyStimulus(1);
    checkAll("tick3", 5'b00000, 0, 0, 1, 0);
    tick = 1'b0;
    applyStimulus(1);
    checkAll("missEnd", 5'b00000, 0, 0, 0, 0);

    // Single hit on hole 2, four cycles after the button rises
    load = 1'b1; load_mask = 5'b00100; load_life = 8'd5;
    applyStimulus(1);
    load = 1'b0;
    checkAll("arm2", 5'b00100, 0, 0, 0, 0);
    button = 5'b00100;
    applyStimulus(3);
    checkAll("hitWait", 5'b00100, 0, 0, 0, 0);
    applyStimulus(1);
    checkAll("hit2", 5'b00000, 1, 1, 0, 0);
    applyStimulus(1);
    checkAll("hit2End", 5'b00000, 0, 0, 0, 0);
    tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOutput("noMissAfterHit", 32'(miss_trigger), 32'd0);
    end
    tick = 1'b0;
    button = '0;
    applyStimulus(4);

    // Three simultaneous hits
    load = 1'b1; load_mask = 5'b10011; load_life = 8'd10;
    applyStimulus(1);
    load = 1'b0;
    checkAll("arm3", 5'b10011, 0, 0, 0, 0);
    button = 5'b10011;
    applyStimulus(4);
    checkAll("hit3", 5'b00000, 1, 3, 0, 0);
    applyStimulus(1);
    checkAll("hit3End", 5'b00000, 0, 0, 0, 0);
    button = '0;
    applyStimulus(4);

    // Whiff on inactive hole 3 while hole 0 is active; holding gives no repeat
    load = 1'b1; load_mask = 5'b00001; load_life = 8'd200;
    applyStimulus(1);
    load = 1'b0;
    button = 5'b01000;
    applyStimulus(4);
    checkAll("whiff", 5'b00001, 0, 0, 0, 1);
    applyStimulus(1);
    checkAll("whiffEnd", 5'b00001, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      checkOutput("heldNoRepeat", 32'(whiff_trigger), 32'd0);
    end
    button = '0;
    applyStimulus(4);

    // Hole 1 at life 1: tick and press in the same cycle scores, no miss
    load = 1'b1; load_mask = 5'b00010; load_life = 8'd1;
    applyStimulus(1);
    load = 1'b0;
    checkAll("arm1", 5'b00011, 0, 0, 0, 0);
    button = 5'b00010;
    applyStimulus(3);
    tick = 1'b1;
    applyStimulus(1);
    tick = 1'b0;
    checkAll("hitBeatsMiss", 5'b00001, 1, 1, 0, 0);

    // Load with life 0 changes nothing
    load = 1'b1; load_mask = 5'b11111; load_life = 8'd0;
    applyStimulus(1);
    load = 1'b0;
    checkAll("loadZero", 5'b00001, 0, 0, 0, 0);
    button = '0;
    applyStimulus(4);

    // Hit on a hole re-armed in the same cycle scores and leaves it active
    load = 1'b1; load_mask = 5'b00010; load_life = 8'd2;
    applyStimulus(1);
    load = 1'b0;
    button = 5'b00010;
    applyStimulus(3);
    load = 1'b1; load_mask = 5'b00010; load_life = 8'd7;
    applyStimulus(1);
    load = 1'b0;
    checkAll("hitReload", 5'b00011, 1, 1, 0, 0);
    tick = 1'b1;
    applyStimulus(2);
    tick = 1'b0;
    checkAll("reloadLife", 5'b00011, 0, 0, 0, 0);

    // Mid-game reset with buttons held, then release with buttons still held
    button = 5'b11111;
    applyStimulus(2);
    rst_n = 1'b0;
    #1;
    checkAll("asyncReset", 5'b00000, 0, 0, 0, 0);
    applyStimulus(3);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("heldThroughReset.score", 32'(score_trigger), 32'd0);
      checkOutput("heldThroughReset.whiff", 32'(whiff_trigger), 32'd0);
    end
    button = '0;
    applyStimulus(4);
    button = 5'b10000;
    applyStimulus(4);
    checkAll("pressAfterReset", 5'b00000, 0, 0, 0, 1);
    button = '0;
    applyStimulus(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
